// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//   RV32I main decoder. The instruction word is decoded combinationally and
//   every control output is registered, so decode results appear one clock
//   after the instruction is presented.
//
// Ports
//   clk             in   1   rising-edge clock
//   rst_n           in   1   asynchronous active-low reset (clears all outputs)
//   instr           in  32   RV32I instruction word
//   alu_pc_select   out  1   ALU operand A = PC (AUIPC, JAL)
//   alu_mux1_select out  1   ALU operand A = 0 (LUI)
//   alu_imm_select  out  1   ALU operand B = immediate (0 = rs2)
//   alu_mux2_select out  2   immediate format 00 I, 01 S, 10 U, 11 J
//   alu_op_select   out  4   ALU operation code
//   rf_w_select     out  2   writeback source 00 ALU, 01 dmem, 10 PC+4
//   w_en_rf         out  1   register-file write enable
//   wr_en_dmem      out  1   data-memory write enable
//   rw_mode         out  4   {unsigned, 0, size[1:0]}; 0000 = no access
//   branch          out  1   conditional branch
//   jump            out  1   JAL / JALR
//
// Any unknown opcode or illegal field combination decodes to all zeros, which
// is an architectural no-op (no writes, no branch, no memory access).
// -----------------------------------------------------------------------------
module control_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  output logic        alu_pc_select,
  output logic        alu_mux1_select,
  output logic        alu_imm_select,
  output logic [1:0]  alu_mux2_select,
  output logic [3:0]  alu_op_select,
  output logic [1:0]  rf_w_select,
  output logic        w_en_rf,
  output logic        wr_en_dmem,
  output logic [3:0]  rw_mode,
  output logic        branch,
  output logic        jump
);

  // Major opcodes (instr[6:0]); all carry the 32-bit marker 2'b11 in [1:0],
  // so compressed/short encodings fall through to the invalid default.
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,  ALU_SUB = 4'd1,  ALU_SLL = 4'd2,  ALU_SLT = 4'd3,
    ALU_SLTU = 4'd4,  ALU_XOR = 4'd5,  ALU_SRL = 4'd6,  ALU_SRA = 4'd7,
    ALU_OR   = 4'd8,  ALU_AND = 4'd9,  ALU_EQ  = 4'd10, ALU_NE  = 4'd11,
    ALU_LT   = 4'd12, ALU_GE  = 4'd13, ALU_LTU = 4'd14, ALU_GEU = 4'd15
  } alu_op_e;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_U = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RF_ALU  = 2'b00;
  localparam logic [1:0] RF_DMEM = 2'b01;
  localparam logic [1:0] RF_PC4  = 2'b10;

  typedef struct packed {
    logic       pc_sel;
    logic       mux1;
    logic       imm_sel;
    logic [1:0] mux2;
    logic [3:0] alu_op;
    logic [1:0] rf_w;
    logic       w_en_rf;
    logic       wr_dmem;
    logic [3:0] rw_mode;
    logic       branch;
    logic       jump;
  } ctrl_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       rd_nz;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rd_nz  = |instr[11:7];

  // Register-source fields are irrelevant to control decode.
  logic unused_rs;
  assign unused_rs = ^instr[24:15];

  // funct3 -> ALU op for the shared register/immediate arithmetic group,
  // before funct7/instr[30] selects SUB or SRA.
  alu_op_e arith_op;
  always_comb begin
    arith_op = ALU_ADD;
    unique case (funct3)
      3'b000: arith_op = ALU_ADD;
      3'b001: arith_op = ALU_SLL;
      3'b010: arith_op = ALU_SLT;
      3'b011: arith_op = ALU_SLTU;
      3'b100: arith_op = ALU_XOR;
      3'b101: arith_op = ALU_SRL;
      3'b110: arith_op = ALU_OR;
      3'b111: arith_op = ALU_AND;
      default: arith_op = ALU_ADD;
    endcase
  end

  // funct3 -> comparison op for conditional branches; 010/011 are reserved.
  alu_op_e br_op;
  logic    br_ok;
  always_comb begin
    br_op = ALU_EQ;
    br_ok = 1'b1;
    unique case (funct3)
      3'b000: br_op = ALU_EQ;
      3'b001: br_op = ALU_NE;
      3'b100: br_op = ALU_LT;
      3'b101: br_op = ALU_GE;
      3'b110: br_op = ALU_LTU;
      3'b111: br_op = ALU_GEU;
      default: br_ok = 1'b0;
    endcase
  end

  ctrl_t ctrl_d, ctrl_q;
  logic  valid;
  logic  writes_rd;

  always_comb begin
    ctrl_d    = '0;
    valid     = 1'b0;
    writes_rd = 1'b0;

    unique case (opcode)
      OPC_OP: begin
        ctrl_d.rf_w = RF_ALU;
        writes_rd   = 1'b1;
        if (funct7 == F7_BASE) begin
          valid         = 1'b1;
          ctrl_d.alu_op = arith_op;
        end else if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000) begin
            valid         = 1'b1;
            ctrl_d.alu_op = ALU_SUB;
          end else if (funct3 == 3'b101) begin
            valid         = 1'b1;
            ctrl_d.alu_op = ALU_SRA;
          end
        end
      end

      OPC_OP_IMM: begin
        ctrl_d.imm_sel = 1'b1;
        ctrl_d.mux2    = IMM_I;
        ctrl_d.rf_w    = RF_ALU;
        ctrl_d.alu_op  = arith_op;
        writes_rd      = 1'b1;
        // Only shifts constrain the upper bits; there they are shamt-adjacent
        // funct7 bits and bit 30 picks arithmetic right shift.
        if (funct3 == 3'b001)
          valid = (funct7 == F7_BASE);
        else if (funct3 == 3'b101) begin
          valid = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          if (funct7 == F7_ALT) ctrl_d.alu_op = ALU_SRA;
        end else
          valid = 1'b1;
      end

      OPC_LOAD: begin
        ctrl_d.imm_sel = 1'b1;
        ctrl_d.mux2    = IMM_I;
        ctrl_d.alu_op  = ALU_ADD;
        ctrl_d.rf_w    = RF_DMEM;
        writes_rd      = 1'b1;
        // size field = funct3[1:0] + 1; funct3[2] flags zero-extension.
        valid          = (funct3[1:0] != 2'b11) && !(funct3[2] && funct3[1]);
        ctrl_d.rw_mode = {funct3[2], 1'b0, funct3[1:0] + 2'd1};
      end

      OPC_STORE: begin
        ctrl_d.imm_sel = 1'b1;
        ctrl_d.mux2    = IMM_S;
        ctrl_d.alu_op  = ALU_ADD;
        ctrl_d.wr_dmem = 1'b1;
        valid          = !funct3[2] && (funct3[1:0] != 2'b11);
        ctrl_d.rw_mode = {2'b00, funct3[1:0] + 2'd1};
      end

      OPC_BRANCH: begin
        ctrl_d.branch = 1'b1;
        ctrl_d.alu_op = br_op;
        valid         = br_ok;
      end

      OPC_JAL: begin
        ctrl_d.jump    = 1'b1;
        ctrl_d.pc_sel  = 1'b1;
        ctrl_d.imm_sel = 1'b1;
        ctrl_d.mux2    = IMM_J;
        ctrl_d.alu_op  = ALU_ADD;
        ctrl_d.rf_w    = RF_PC4;
        writes_rd      = 1'b1;
        valid          = 1'b1;
      end

      OPC_JALR: begin
        ctrl_d.jump    = 1'b1;
        ctrl_d.imm_sel = 1'b1;
        ctrl_d.mux2    = IMM_I;
        ctrl_d.alu_op  = ALU_ADD;
        ctrl_d.rf_w    = RF_PC4;
        writes_rd      = 1'b1;
        valid          = (funct3 == 3'b000);
      end

      OPC_LUI: begin
        ctrl_d.mux1    = 1'b1;
        ctrl_d.imm_sel = 1'b1;
        ctrl_d.mux2    = IMM_U;
        ctrl_d.alu_op  = ALU_ADD;
        ctrl_d.rf_w    = RF_ALU;
        writes_rd      = 1'b1;
        valid          = 1'b1;
      end

      OPC_AUIPC: begin
        ctrl_d.pc_sel  = 1'b1;
        ctrl_d.imm_sel = 1'b1;
        ctrl_d.mux2    = IMM_U;
        ctrl_d.alu_op  = ALU_ADD;
        ctrl_d.rf_w    = RF_ALU;
        writes_rd      = 1'b1;
        valid          = 1'b1;
      end

      default: valid = 1'b0;
    endcase

    // Writes to x0 are discarded at the source.
    if (writes_rd) ctrl_d.w_en_rf = rd_nz;
    if (!valid)    ctrl_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ctrl_q <= '0;
    else        ctrl_q <= ctrl_d;
  end

  assign alu_pc_select   = ctrl_q.pc_sel;
  assign alu_mux1_select = ctrl_q.mux1;
  assign alu_imm_select  = ctrl_q.imm_sel;
  assign alu_mux2_select = ctrl_q.mux2;
  assign alu_op_select   = ctrl_q.alu_op;
  assign rf_w_select     = ctrl_q.rf_w;
  assign w_en_rf         = ctrl_q.w_en_rf;
  assign wr_en_dmem      = ctrl_q.wr_dmem;
  assign rw_mode         = ctrl_q.rw_mode;
  assign branch          = ctrl_q.branch;
  assign jump            = ctrl_q.jump;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed encodings with hand-written expectations,
// reset behaviour, then random instructions against a table-driven model.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic        alu_pc_select, alu_mux1_select, alu_imm_select;
  logic [1:0]  alu_mux2_select, rf_w_select;
  logic [3:0]  alu_op_select, rw_mode;
  logic        w_en_rf, wr_en_dmem, branch, jump;

  control_unit dut (
    .clk(clk), .rst_n(rst_n), .instr(instr),
    .alu_pc_select(alu_pc_select), .alu_mux1_select(alu_mux1_select),
    .alu_imm_select(alu_imm_select), .alu_mux2_select(alu_mux2_select),
    .alu_op_select(alu_op_select), .rf_w_select(rf_w_select),
    .w_en_rf(w_en_rf), .wr_en_dmem(wr_en_dmem), .rw_mode(rw_mode),
    .branch(branch), .jump(jump)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // {pc, mux1, imm, mux2[2], op[4], rfw[2], wen, wdmem, rw[4], br, jmp}
  function automatic logic [18:0] pk(input logic pc, input logic m1, input logic im,
                                     input logic [1:0] m2, input logic [3:0] op,
                                     input logic [1:0] rfw, input logic wen,
                                     input logic wd, input logic [3:0] rw,
                                     input logic br, input logic jp);
    return {pc, m1, im, m2, op, rfw, wen, wd, rw, br, jp};
  endfunction

  function automatic logic [18:0] observed();
    return pk(alu_pc_select, alu_mux1_select, alu_imm_select, alu_mux2_select,
              alu_op_select, rf_w_select, w_en_rf, wr_en_dmem, rw_mode, branch, jump);
  endfunction

  task automatic chk(input string tag, input logic [18:0] got, input logic [18:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s instr=%08h got=%05h expected=%05h", tag, instr, got, exp);
    end
  endtask

  // Reference decode, written from the instruction-set tables.
  function automatic logic [18:0] model(input logic [31:0] w);
    logic [6:0] opc; logic [2:0] f3; logic [6:0] f7; logic wen;
    int arith [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    int bops  [8] = '{10, 11, -1, -1, 12, 13, 14, 15};
    opc = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    wen = (w[11:7] != 5'd0);
    if (opc == 7'h33) begin
      if (f7 == 7'h00) return pk(0,0,0,2'd0,4'(arith[f3]),2'd0,wen,0,4'd0,0,0);
      if (f7 == 7'h20 && f3 == 3'd0) return pk(0,0,0,2'd0,4'd1,2'd0,wen,0,4'd0,0,0);
      if (f7 == 7'h20 && f3 == 3'd5) return pk(0,0,0,2'd0,4'd7,2'd0,wen,0,4'd0,0,0);
      return '0;
    end
    if (opc == 7'h13) begin
      if (f3 == 3'd1 && f7 != 7'h00) return '0;
      if (f3 == 3'd5 && f7 == 7'h20) return pk(0,0,1,2'd0,4'd7,2'd0,wen,0,4'd0,0,0);
      if (f3 == 3'd5 && f7 != 7'h00) return '0;
      return pk(0,0,1,2'd0,4'(arith[f3]),2'd0,wen,0,4'd0,0,0);
    end
    if (opc == 7'h03) begin
      case (f3)
        3'd0: return pk(0,0,1,2'd0,4'd0,2'd1,wen,0,4'b0001,0,0);
        3'd1: return pk(0,0,1,2'd0,4'd0,2'd1,wen,0,4'b0010,0,0);
        3'd2: return pk(0,0,1,2'd0,4'd0,2'd1,wen,0,4'b0011,0,0);
        3'd4: return pk(0,0,1,2'd0,4'd0,2'd1,wen,0,4'b1001,0,0);
        3'd5: return pk(0,0,1,2'd0,4'd0,2'd1,wen,0,4'b1010,0,0);
        default: return '0;
      endcase
    end
    if (opc == 7'h23) begin
      if (f3 > 3'd2) return '0;
      return pk(0,0,1,2'd1,4'd0,2'd0,0,1,4'(f3 + 1),0,0);
    end
    if (opc == 7'h63) begin
      if (bops[f3] < 0) return '0;
      return pk(0,0,0,2'd0,4'(bops[f3]),2'd0,0,0,4'd0,1,0);
    end
    if (opc == 7'h6F) return pk(1,0,1,2'd3,4'd0,2'd2,wen,0,4'd0,0,1);
    if (opc == 7'h67) return (f3 == 3'd0) ? pk(0,0,1,2'd0,4'd0,2'd2,wen,0,4'd0,0,1) : 19'd0;
    if (opc == 7'h37) return pk(0,1,1,2'd2,4'd0,2'd0,wen,0,4'd0,0,0);
    if (opc == 7'h17) return pk(1,0,1,2'd2,4'd0,2'd0,wen,0,4'd0,0,0);
    return '0;
  endfunction

  // Present an instruction between edges, clock it in, sample just after.
  task automatic apply(input logic [31:0] w);
    @(negedge clk);
    instr = w;
    @(posedge clk);
    #1;
  endtask

  task automatic dir(input string tag, input logic [31:0] w, input logic [18:0] exp);
    apply(w);
    chk(tag, observed(), exp);
  endtask

  initial begin
    logic [6:0] opcs [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
                              7'h67, 7'h37, 7'h17, 7'h0F, 7'h73};
    logic [31:0] w;
    logic [6:0]  f7;

    #2;
    chk("reset_state", observed(), 19'd0);
    instr = 32'h00418133;
    @(posedge clk); #1;
    chk("reset_held_over_edge", observed(), 19'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("first_edge_after_reset", observed(), pk(0,0,0,2'd0,4'd0,2'd0,1,0,4'd0,0,0));

    dir("ADD",   32'h00418133, pk(0,0,0,2'd0,4'd0,2'd0,1,0,4'd0,0,0));
    dir("SUB",   32'h40418133, pk(0,0,0,2'd0,4'd1,2'd0,1,0,4'd0,0,0));
    dir("ADDI",  32'h00418113, pk(0,0,1,2'd0,4'd0,2'd0,1,0,4'd0,0,0));
    dir("LW",    32'h00822183, pk(0,0,1,2'd0,4'd0,2'd1,1,0,4'b0011,0,0));
    dir("SW",    32'h0041A623, pk(0,0,1,2'd1,4'd0,2'd0,0,1,4'b0011,0,0));
    dir("BGE",   32'h0041D063, pk(0,0,0,2'd0,4'd13,2'd0,0,0,4'd0,1,0));
    dir("JAL",   32'h000001EF, pk(1,0,1,2'd3,4'd0,2'd2,1,0,4'd0,0,1));
    dir("JALR",  32'h078201E7, pk(0,0,1,2'd0,4'd0,2'd2,1,0,4'd0,0,1));
    dir("LUI",   32'h00002537, pk(0,1,1,2'd2,4'd0,2'd0,1,0,4'd0,0,0));
    dir("AUIPC", 32'h00002797, pk(1,0,1,2'd2,4'd0,2'd0,1,0,4'd0,0,0));
    dir("NOP_x0",32'h00000013, pk(0,0,1,2'd0,4'd0,2'd0,0,0,4'd0,0,0));
    dir("SRAI",  32'h40315193, pk(0,0,1,2'd0,4'd7,2'd0,1,0,4'd0,0,0));
    dir("LHU",   32'h00825183, pk(0,0,1,2'd0,4'd0,2'd1,1,0,4'b1010,0,0));
    dir("zero",  32'h00000000, 19'd0);
    dir("bad_f7",32'h40419133, 19'd0);
    dir("bad_ld",32'h00823183, 19'd0);
    dir("bad_br",32'h0041A063, 19'd0);
    dir("bad_lo",32'h00418131, 19'd0);
    dir("FENCE", 32'h0000000F, 19'd0);
    dir("slli7", 32'h40319193, 19'd0);

    // Mid-cycle reset clears immediately; the pending instruction is lost.
    apply(32'h000001EF);
    @(negedge clk);
    instr = 32'h00418133;
    #2 rst_n = 1'b0;
    #1 chk("async_clear", observed(), 19'd0);
    @(posedge clk); #1;
    chk("inflight_lost", observed(), 19'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("resume_after_reset", observed(), model(instr));

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 2))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        default: f7 = 7'($urandom);
      endcase
      w = $urandom;
      w[31:25] = f7;
      w[6:0] = ($urandom_range(0, 9) == 0) ? 7'($urandom) : opcs[$urandom_range(0, 10)];
      if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
      apply(w);
      chk("random", observed(), model(w));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL use one clock; reset SHALL be asynchronous and active-low. Ports clk and rst_n.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 instr  input  32  RV32I instruction word.
REQ-006 alu_pc_select  output  1  ALU operand A = PC (AUIPC, JAL).
REQ-007 alu_mux1_select  output  1  ALU operand A = constant 0 (LUI).
REQ-008 alu_imm_select  output  1  ALU operand B = immediate; 0 = rs2.
REQ-009 alu_mux2_select  output  2  immediate format: 00 I, 01 S, 10 U, 11 J.
REQ-010 alu_op_select  output  4  ALU operation code.
REQ-011 rf_w_select  output  2  writeback source: 00 ALU, 01 dmem data, 10 PC+4, 11 unused.
REQ-012 w_en_rf  output  1  register-file write enable.
REQ-013 wr_en_dmem  output  1  data-memory write enable.
REQ-014 rw_mode  output  4  memory access mode: bit3 = unsigned, bits1:0 size (01 byte, 10 half, 11 word); 0000 = no access.
REQ-015 branch  output  1  conditional branch.
REQ-016 jump  output  1  JAL/JALR.

Function
REQ-017 Decode SHALL be combinational from instr. All outputs SHALL be registered on the rising clk edge, giving 1-cycle latency.
REQ-018 alu_op_select SHALL be: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 EQ, 11 NE, 12 LT, 13 GE, 14 LTU, 15 GEU.
REQ-019 OP (0110011): B=rs2 and rf_w=00. The op SHALL follow funct3/funct7. funct7 0100000 SHALL be valid only with funct3 000 (SUB) and 101 (SRA); any other funct7 SHALL be invalid.
REQ-020 OP-IMM (0010011): imm_select=1, mux2=00, rf_w=00. SLLI/SRLI/SRAI SHALL be selected by instr[30]. Any other instr[31:25] on a shift SHALL be invalid.
REQ-021 LOAD (0000011): ADD, imm I, rf_w=01. rw_mode SHALL be: LB 0001, LH 0010, LW 0011, LBU 1001, LHU 1010. Other funct3 values SHALL be invalid.
REQ-022 STORE (0100011): ADD, imm S, wr_en_dmem=1, w_en_rf=0. rw_mode SHALL be: SB 0001, SH 0010, SW 0011. Other funct3 values SHALL be invalid.
REQ-023 BRANCH (1100011): branch=1, B=rs2, w_en_rf=0. funct3 SHALL map BEQ 10, BNE 11, BLT 12, BGE 13, BLTU 14, BGEU 15. funct3 010/011 SHALL be invalid.
REQ-024 JAL (1101111): jump=1, pc_select=1, imm J, ADD, rf_w=10.
REQ-025 JALR (1100111, funct3 000): jump=1, A=rs1, imm I, ADD, rf_w=10. Other funct3 values SHALL be invalid.
REQ-026 LUI (0110111): mux1=1, imm U, ADD, rf_w=00.
REQ-027 AUIPC (0010111): pc_select=1, imm U, ADD, rf_w=00.
REQ-028 For register-writing instructions, w_en_rf SHALL be 1 unless rd (instr[11:7]) = 0, in which case it SHALL be 0.
REQ-029 Every output not named for an opcode SHALL be 0.
REQ-030 Any unlisted opcode, including FENCE/SYSTEM, or any invalid field SHALL produce all outputs 0.
REQ-031 instr[1:0] != 11 SHALL be invalid.

Reset
REQ-032 While rst_n=0, all outputs SHALL be 0 immediately, independent of clk.
REQ-033 After rst_n rises, the first rising clk edge SHALL load the decode of the current instr.
REQ-034 If reset is asserted mid-stream, the registered outputs SHALL be cleared and the instruction in flight SHALL be lost.

Verification
REQ-035 instr 0x00418133 (ADD x2,x3,x4) -> after 1 edge: op 0, imm_sel 0, rf_w 00, w_en_rf 1, other outputs 0.
REQ-036 0x40418133 (SUB) -> op 1. 0x00418113 (ADDI x2,x3,4) -> op 0, imm_sel 1, mux2 00, w_en_rf 1.
REQ-037 0x00822183 (LW x3,8(x4)) -> rf_w 01, rw_mode 0011, imm_sel 1, w_en_rf 1. SW x4,12(x3) -> wr_en_dmem 1, rw_mode 0011, mux2 01, w_en_rf 0.
REQ-038 BGE x3,x4 -> branch 1, op 13, w_en_rf 0. JAL x3 -> jump 1, pc_sel 1, mux2 11, rf_w 10. JALR x3,120(x4) -> jump 1, pc_sel 0, rf_w 10.
REQ-039 0x00002537 (LUI x10,2) -> mux1 1, mux2 10, w_en_rf 1. AUIPC x15,2 -> pc_sel 1, mux2 10. ADDI x0,x0,0 -> w_en_rf 0.
REQ-040 instr 0x00000000 -> all outputs 0. Asserting rst_n=0 between clk edges -> all outputs 0 without waiting for an edge.
